// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT64 framing logic.
package fft_pkg;

  localparam int FFT_N     = 64;
  localparam int FFT_LOG2N = 6;
  localparam int FFT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PAD  = 2'd2
  } in_state_e;

  typedef struct packed {
    logic [FFT_WIDTH-1:0] re;
    logic [FFT_WIDTH-1:0] im;
  } fft_sample_t;

endpackage

// File: rtl/fft_tag_fifo.sv
// Small synchronous tag FIFO; push and pop may occur in the same cycle, even when full.
module fft_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = ptr_next(wr_q);
    end
    if (do_pop) rd_d = ptr_next(rd_q);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frames an upstream sample stream into whole N-sample bursts for FFT64, limits
// frames in flight, and re-frames the core output with sof/eof markers and tag.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int N            = FFT_N,
  parameter int WIDTH        = FFT_WIDTH,
  parameter int TAG_W        = 4,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  input  logic [TAG_W-1:0] in_tag,
  output logic             fft_di_en,
  output logic [WIDTH-1:0] fft_di_re,
  output logic [WIDTH-1:0] fft_di_im,
  input  logic             fft_do_en,
  input  logic [WIDTH-1:0] fft_do_re,
  input  logic [WIDTH-1:0] fft_do_im,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       inflight,
  output logic             err_underrun,
  output logic             err_orphan,
  input  logic             err_clr
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  in_state_e        state_q, state_d;
  logic [CW-1:0]    in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic             di_en_q, di_en_d;
  logic [WIDTH-1:0] di_re_q, di_re_d, di_im_q, di_im_d;
  logic             ov_q, ov_d, sof_q, sof_d, eof_q, eof_d;
  logic [WIDTH-1:0] ore_q, ore_d, oim_q, oim_d;
  logic [TAG_W-1:0] otag_q, otag_d, tag_head;
  logic [2:0]       inflight_q, inflight_d;
  logic             und_q, und_d, orph_q, orph_d;
  logic             accept, start, set_und, orphan, eof_now, pop, tag_full, tag_empty;

  fft_tag_fifo #(.DEPTH(MAX_INFLIGHT), .W(TAG_W)) u_tag_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (start && !tag_full),
    .pop   (pop),
    .din   (in_tag),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  always_comb begin
    case (state_q)
      ST_IDLE: in_ready = (inflight_q < 3'(MAX_INFLIGHT));
      ST_RUN:  in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
    accept   = in_valid && in_ready;
    start    = (state_q == ST_IDLE) && accept;
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    di_en_d  = 1'b0;
    di_re_d  = '0;
    di_im_d  = '0;
    set_und  = 1'b0;
    // Every RUN/PAD cycle is a core slot; an underrun slot carries a zero sample.
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_RUN;
          in_cnt_d = CW'(1);
          di_en_d  = 1'b1;
          di_re_d  = in_re;
          di_im_d  = in_im;
        end
      end
      ST_RUN: begin
        di_en_d  = 1'b1;
        in_cnt_d = in_cnt_q + 1'b1;
        if (accept) begin
          di_re_d = in_re;
          di_im_d = in_im;
        end else begin
          set_und = 1'b1;
        end
        if (in_cnt_q == CNT_LAST) state_d = ST_IDLE;
        else if (!in_valid)       state_d = ST_PAD;
      end
      ST_PAD: begin
        di_en_d  = 1'b1;
        in_cnt_d = in_cnt_q + 1'b1;
        if (in_cnt_q == CNT_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    orphan    = fft_do_en && (inflight_q == '0);
    eof_now   = fft_do_en && (out_cnt_q == CNT_LAST);
    pop       = eof_now && !orphan;
    out_cnt_d = fft_do_en ? out_cnt_q + 1'b1 : out_cnt_q;
    ov_d      = fft_do_en;
    sof_d     = fft_do_en && (out_cnt_q == '0);
    eof_d     = eof_now;
    ore_d     = fft_do_en ? fft_do_re : '0;
    oim_d     = fft_do_en ? fft_do_im : '0;
    otag_d    = (fft_do_en && !orphan && !tag_empty) ? tag_head : '0;
    inflight_d = inflight_q;
    if (start && !pop)      inflight_d = inflight_q + 3'd1;
    else if (!start && pop) inflight_d = inflight_q - 3'd1;
    und_d  = set_und ? 1'b1 : (err_clr ? 1'b0 : und_q);
    orph_d = orphan  ? 1'b1 : (err_clr ? 1'b0 : orph_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      di_en_q    <= 1'b0;
      di_re_q    <= '0;
      di_im_q    <= '0;
      ov_q       <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      ore_q      <= '0;
      oim_q      <= '0;
      otag_q     <= '0;
      inflight_q <= '0;
      und_q      <= 1'b0;
      orph_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      di_en_q    <= di_en_d;
      di_re_q    <= di_re_d;
      di_im_q    <= di_im_d;
      ov_q       <= ov_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      ore_q      <= ore_d;
      oim_q      <= oim_d;
      otag_q     <= otag_d;
      inflight_q <= inflight_d;
      und_q      <= und_d;
      orph_q     <= orph_d;
    end
  end

  assign fft_di_en    = di_en_q;
  assign fft_di_re    = di_re_q;
  assign fft_di_im    = di_im_q;
  assign out_valid    = ov_q;
  assign out_sof      = sof_q;
  assign out_eof      = eof_q;
  assign out_re       = ore_q;
  assign out_im       = oim_q;
  assign out_tag      = otag_q;
  assign inflight     = inflight_q;
  assign err_underrun = und_q;
  assign err_orphan   = orph_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed + randomized bench for fft_frame_ctrl against a frame-level reference model.
module tb_fft_frame_ctrl;
  import fft_pkg::*;

  localparam int N    = 64;
  localparam int W    = 16;
  localparam int TW   = 4;
  localparam int MAXI = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_re = '0, in_im = '0;
  logic [TW-1:0] in_tag = '0;
  logic          fft_di_en;
  logic [W-1:0]  fft_di_re, fft_di_im;
  logic          fft_do_en = 1'b0;
  logic [W-1:0]  fft_do_re = '0, fft_do_im = '0;
  logic          out_valid, out_sof, out_eof;
  logic [W-1:0]  out_re, out_im;
  logic [TW-1:0] out_tag;
  logic [2:0]    inflight;
  logic          err_underrun, err_orphan;
  logic          err_clr = 1'b0;

  fft_frame_ctrl #(.N(N), .WIDTH(W), .TAG_W(TW), .MAX_INFLIGHT(MAXI)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im), .in_tag(in_tag),
    .fft_di_en(fft_di_en), .fft_di_re(fft_di_re), .fft_di_im(fft_di_im),
    .fft_do_en(fft_do_en), .fft_do_re(fft_do_re), .fft_do_im(fft_do_im),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_re(out_re), .out_im(out_im), .out_tag(out_tag),
    .inflight(inflight), .err_underrun(err_underrun), .err_orphan(err_orphan),
    .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  typedef struct {
    fft_sample_t   s;
    logic [TW-1:0] tag;
  } src_t;

  src_t          src[$];
  logic [TW-1:0] tagq[$];
  logic [TW-1:0] seen_tags[$];
  int  m_inflight, ocnt, pos;
  bit  in_frame, padding, m_und, m_orph;
  int  n_assert = 0, n_fail = 0;
  int  cyc_n = 0, di_seen = 0, first_eof = -1, do_left = 0;
  int  start_cyc[16];
  bit  offer = 1'b0, rnd = 1'b0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic chk_tags(input string name, input int n, input int t0, input int t1, input int t2);
    int e[3];
    e = '{t0, t1, t2};
    chk({name, "_count"}, seen_tags.size(), n);
    for (int i = 0; i < n && i < seen_tags.size(); i++) chk(name, seen_tags[i], e[i]);
  endtask

  task automatic model_reset();
    tagq.delete();
    m_inflight = 0; ocnt = 0; pos = 0;
    in_frame = 1'b0; padding = 1'b0; m_und = 1'b0; m_orph = 1'b0;
  endtask

  task automatic queue_frame(input logic [TW-1:0] tag, input int n, input bit ramp);
    src_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = tag;
      if (ramp) begin
        e.s.re = W'(i);
        e.s.im = W'(-i);
      end else begin
        e.s.re = W'($urandom);
        e.s.im = W'($urandom);
      end
      src.push_back(e);
    end
  endtask

  task automatic drive_inputs();
    in_valid = offer && (src.size() > 0);
    if (in_valid) begin
      in_re  = src[0].s.re;
      in_im  = src[0].s.im;
      in_tag = src[0].tag;
    end else begin
      in_re  = W'($urandom);
      in_im  = W'($urandom);
      in_tag = TW'($urandom);
    end
    if (rnd) begin
      fft_do_en = ((m_inflight > 0) && ($urandom_range(0, 3) != 0)) || ($urandom_range(0, 99) == 0);
    end else begin
      fft_do_en = (do_left > 0);
      if (do_left > 0) do_left--;
    end
    fft_do_re = W'($urandom);
    fft_do_im = W'($urandom);
  endtask

  // One clock cycle: drive, predict at the falling edge, check registered outputs after the rise.
  task automatic cyc();
    bit            exp_rdy, all_zero, e_di_en, e_ov, e_sof, e_eof, set_u, set_o;
    logic [W-1:0]  e_di_re, e_di_im, e_ore, e_oim;
    logic [TW-1:0] e_otag;
    drive_inputs();
    @(negedge clock);
    cyc_n++;
    if (out_valid === 1'b1 && out_sof === 1'b1) seen_tags.push_back(out_tag);
    if (out_valid === 1'b1 && out_eof === 1'b1 && first_eof < 0) first_eof = cyc_n;
    exp_rdy = in_frame ? !padding : (m_inflight < MAXI);
    if (!reset) chk("in_ready", in_ready, exp_rdy);
    e_di_en = 0; e_di_re = '0; e_di_im = '0;
    e_ov = 0; e_sof = 0; e_eof = 0; e_ore = '0; e_oim = '0; e_otag = '0;
    set_u = 0; set_o = 0;
    all_zero = reset;
    if (reset) begin
      model_reset();
    end else begin
      if (fft_do_en) begin
        e_ov  = 1; e_sof = (ocnt == 0); e_eof = (ocnt == N - 1);
        e_ore = fft_do_re; e_oim = fft_do_im;
        if (m_inflight == 0) begin
          set_o = 1;
        end else begin
          e_otag = tagq[0];
          if (e_eof) begin
            void'(tagq.pop_front());
            m_inflight--;
          end
        end
        ocnt = (ocnt + 1) % N;
      end
      if (!in_frame) begin
        if (in_valid && exp_rdy) begin
          e_di_en = 1; e_di_re = in_re; e_di_im = in_im;
          tagq.push_back(in_tag);
          m_inflight++;
          start_cyc[in_tag] = cyc_n;
          in_frame = 1; padding = 0; pos = 1;
          void'(src.pop_front());
        end
      end else begin
        e_di_en = 1;
        if (!padding && in_valid) begin
          e_di_re = in_re; e_di_im = in_im;
          void'(src.pop_front());
        end else begin
          if (!padding) set_u = 1;
          padding = 1;
        end
        pos++;
        if (pos == N) begin
          in_frame = 0; padding = 0;
        end
      end
      m_und  = set_u ? 1'b1 : (err_clr ? 1'b0 : m_und);
      m_orph = set_o ? 1'b1 : (err_clr ? 1'b0 : m_orph);
    end
    @(posedge clock);
    #1;
    if (fft_di_en === 1'b1) di_seen++;
    chk("di_en", fft_di_en, e_di_en);
    if (e_di_en || all_zero) begin
      chk("di_re", fft_di_re, e_di_re);
      chk("di_im", fft_di_im, e_di_im);
    end
    chk("out_valid", out_valid, e_ov);
    if (e_ov || all_zero) begin
      chk("out_sof", out_sof, e_sof);
      chk("out_eof", out_eof, e_eof);
      chk("out_re", out_re, e_ore);
      chk("out_im", out_im, e_oim);
      chk("out_tag", out_tag, e_otag);
    end
    chk("inflight", inflight, m_inflight);
    chk("err_underrun", err_underrun, m_und);
    chk("err_orphan", err_orphan, m_orph);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) start_cyc[i] = -1;
    model_reset();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;

    // Single frame, ramp data, tag 5
    queue_frame(4'd5, 64, 1'b1);
    offer = 1'b1; di_seen = 0; seen_tags.delete();
    repeat (66) cyc();
    chk("s1_di_count", di_seen, 64);
    chk("s1_inflight_up", inflight, 1);
    do_left = 64;
    repeat (66) cyc();
    chk("s1_inflight_down", inflight, 0);
    chk_tags("s1_tags", 1, 5, 0, 0);

    // Underrun after 21 samples
    di_seen = 0; seen_tags.delete();
    queue_frame(4'd7, 21, 1'b0);
    repeat (70) cyc();
    chk("s2_di_count", di_seen, 64);
    chk("s2_underrun", err_underrun, 1);
    repeat (5) cyc();
    chk("s2_underrun_sticky", err_underrun, 1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("s2_underrun_clr", err_underrun, 0);
    do_left = 64;
    repeat (66) cyc();
    chk("s2_inflight_down", inflight, 0);
    chk_tags("s2_tags", 1, 7, 0, 0);

    // In-flight limit: three frames offered, core output held off
    di_seen = 0; seen_tags.delete(); first_eof = -1;
    for (int i = 0; i < 16; i++) start_cyc[i] = -1;
    queue_frame(4'd1, 64, 1'b1);
    queue_frame(4'd2, 64, 1'b0);
    queue_frame(4'd3, 64, 1'b0);
    repeat (140) cyc();
    chk("s3_di_count", di_seen, 128);
    chk("s3_inflight", inflight, 2);
    chk("s3_ready_low", in_ready, 0);
    chk("s3_gapless", start_cyc[2] - start_cyc[1], 64);
    do_left = 192;
    repeat (200) cyc();
    chk("s3_start3_after_eof", start_cyc[3], first_eof);
    chk("s3_inflight_down", inflight, 0);
    chk_tags("s3_tags", 3, 1, 2, 3);

    // Frame start coinciding with an output eof
    seen_tags.delete();
    queue_frame(4'd9, 64, 1'b0);
    repeat (66) cyc();
    chk("s4_inflight_pre", inflight, 1);
    queue_frame(4'd10, 64, 1'b0);
    offer = 1'b0; do_left = 64;
    repeat (63) cyc();
    offer = 1'b1;
    cyc();
    chk("s4_eof", out_eof, 1);
    chk("s4_start", fft_di_en, 1);
    chk("s4_inflight_same", inflight, 1);
    repeat (66) cyc();
    do_left = 64;
    repeat (66) cyc();
    chk("s4_inflight_down", inflight, 0);
    chk_tags("s4_tags", 2, 9, 10, 0);

    // Orphan core output
    do_left = 1;
    cyc();
    chk("s5_orphan", err_orphan, 1);
    chk("s5_valid", out_valid, 1);
    chk("s5_tag", out_tag, 0);
    chk("s5_inflight", inflight, 0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("s5_orphan_clr", err_orphan, 0);

    // Reset in the middle of a frame
    queue_frame(4'd11, 64, 1'b1);
    repeat (30) cyc();
    reset = 1'b1;
    src.delete();
    cyc();
    chk("s6_di_en_off", fft_di_en, 0);
    chk("s6_inflight", inflight, 0);
    reset = 1'b0;
    di_seen = 0; seen_tags.delete();
    queue_frame(4'd12, 64, 1'b1);
    repeat (66) cyc();
    chk("s6_di_count", di_seen, 64);
    chk("s6_inflight_up", inflight, 1);
    do_left = 64;
    repeat (66) cyc();
    chk("s6_inflight_down", inflight, 0);
    chk_tags("s6_tags", 1, 12, 0, 0);

    // Randomized traffic
    rnd = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (src.size() < 64 && $urandom_range(0, 3) == 0) queue_frame(TW'($urandom), 64, 1'b0);
      offer   = ($urandom_range(0, 15) != 0);
      err_clr = ($urandom_range(0, 31) == 0);
      cyc();
    end
    rnd = 1'b0; err_clr = 1'b0; offer = 1'b0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
